// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word RAM with programmable wait states, a
// two-state stall FSM, and the registered hand-off to write-back.
module mem_stage #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] rb_data,
  input  logic [31:0] mxpc_in,
  input  logic        alu_O,
  input  logic        alu_S,
  input  logic        alu_C,
  input  logic        alu_Z,
  input  logic        uc_R_DM,
  input  logic        uc_W_DM,
  input  logic [1:0]  uc_S_MXRB,
  input  logic [2:0]  uc_W_RF,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] wb_dm_Q,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_mxpc_out,
  output logic        wb_alu_O,
  output logic        wb_alu_S,
  output logic        wb_alu_C,
  output logic        wb_alu_Z,
  output logic [1:0]  wb_uc_S_MXRB,
  output logic [2:0]  wb_uc_W_RF,
  output logic        dbg_state
);

  // Handshake: the stage consumes the presented instruction on an edge where
  // in_valid=1 and stall=0; while stall=1 upstream holds every input stable.

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [31:0] r_mem [2**ADDR_BITS];

  logic                 w_mem_op;
  logic                 w_commit_raw;
  logic                 w_commit;
  logic                 w_stall_raw;
  logic [ADDR_BITS-1:0] w_addr;
  logic [31:0]          w_rdata;

  assign w_mem_op = in_valid & (uc_R_DM | uc_W_DM);
  assign w_addr   = alu_result[ADDR_BITS-1:0];
  assign w_rdata  = r_mem[w_addr];

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_commit_raw = 1'b0;
    w_stall_raw  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (!w_mem_op || (LP_WAIT == 4'd0)) begin
            w_commit_raw = 1'b1;
          end else begin
            w_stall_raw = 1'b1;
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = LP_WAIT - 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (!in_valid) begin
          // Upstream withdrew mid-access: abandon it without touching RAM.
          w_state_nxt = S_IDLE;
        end else if (r_cnt != 4'd0) begin
          w_stall_raw = 1'b1;
          w_cnt_nxt   = r_cnt - 4'd1;
        end else begin
          w_commit_raw = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Reset must also block the RAM write, which has no reset of its own.
  assign w_commit  = w_commit_raw & ~RESET;
  assign stall     = w_stall_raw & ~RESET;
  assign dbg_state = (r_state == S_WAIT);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_commit && uc_W_DM) r_mem[w_addr] <= rb_data;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_valid     <= 1'b0;
      wb_dm_Q       <= 32'h0;
      wb_alu_result <= 32'h0;
      wb_mxpc_out   <= 32'h0;
      wb_alu_O      <= 1'b0;
      wb_alu_S      <= 1'b0;
      wb_alu_C      <= 1'b0;
      wb_alu_Z      <= 1'b0;
      wb_uc_S_MXRB  <= 2'b00;
      wb_uc_W_RF    <= 3'b000;
    end else begin
      out_valid  <= w_commit;
      wb_uc_W_RF <= w_commit ? uc_W_RF : 3'b000;
      if (w_commit) begin
        // Non-blocking read sees the pre-store word on a combined load/store.
        wb_dm_Q       <= uc_R_DM ? w_rdata : 32'h0;
        wb_alu_result <= alu_result;
        wb_mxpc_out   <= mxpc_in;
        wb_alu_O      <= alu_O;
        wb_alu_S      <= alu_S;
        wb_alu_C      <= alu_C;
        wb_alu_Z      <= alu_Z;
        wb_uc_S_MXRB  <= uc_S_MXRB;
      end
    end
  end

endmodule
